// File: rtl/jts16_map_pkg.sv
// Shared constants and payload types for the tile-map read arbiter.
package jts16_map_pkg;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned MAP_AW = 14;

  // Requester ids
  localparam logic [1:0] SCR1 = 2'd0;
  localparam logic [1:0] SCR2 = 2'd1;
  localparam logic [1:0] CHAR = 2'd2;

  // One read travelling through the memory pipeline
  typedef struct packed {
    logic              valid;
    logic [1:0]        id;
    logic [MAP_AW-1:0] addr;
  } map_flight_t;

endpackage

// File: rtl/jts16_map_rr.sv
// Combinational 3-way round-robin picker: first pending index starting at rr.
module jts16_map_rr
  import jts16_map_pkg::*;
(
  input  logic [NREQ-1:0] pend,
  input  logic [1:0]      rr,
  output logic [1:0]      gnt_id,
  output logic            gnt_vld
);

  int s;

  // Scan from the farthest candidate back to rr so the nearest pending one wins
  always_comb begin
    gnt_id  = 2'd0;
    gnt_vld = 1'b0;
    s       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = int'(rr) + k;
      if (s >= int'(NREQ)) s = s - int'(NREQ);
      if (s >= int'(NREQ)) s = s - int'(NREQ);
      if (pend[s]) begin
        gnt_id  = 2'(s);
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jts16_map_arb.sv
// Shares one pipelined map-RAM read port among scroll 1, scroll 2 and char fetchers.
module jts16_map_arb
  import jts16_map_pkg::*;
#(
  parameter int unsigned AW  = 14,
  parameter int unsigned DW  = 16,
  parameter int unsigned LAT = 2
)(
  input  logic                 rst,
  input  logic                 clk,
  input  logic [NREQ*AW-1:0]   req_addr,
  output logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ok,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_rd,
  input  logic [DW-1:0]        mem_data
);

  logic [AW-1:0]   addr_in  [NREQ];
  logic [AW-1:0]   srv_addr [NREQ];
  logic [DW-1:0]   data_q   [NREQ];
  logic [NREQ-1:0] valid, busy, pend;
  logic [NREQ-1:0] gnt_mask, ret_mask;
  logic [1:0]      rr, gnt_id;
  logic            gnt_vld;
  logic [AW-1:0]   gnt_addr;
  map_flight_t     flight [LAT];
  map_flight_t     ret;

  assign ret = flight[LAT-1];

  // Per-requester unpacking, pending and ok flags
  genvar gi;
  generate
    for (gi = 0; gi < int'(NREQ); gi++) begin : g_req
      assign addr_in[gi]           = req_addr[gi*AW +: AW];
      assign req_data[gi*DW +: DW] = data_q[gi];
      assign pend[gi]     = !busy[gi] && (!valid[gi] || addr_in[gi] != srv_addr[gi]);
      assign req_ok[gi]   = valid[gi] && (addr_in[gi] == srv_addr[gi]) && !busy[gi];
      assign gnt_mask[gi] = gnt_vld && (gnt_id == 2'(gi));
      assign ret_mask[gi] = ret.valid && (ret.id == 2'(gi));
    end
  endgenerate

  jts16_map_rr u_rr (
    .pend    (pend),
    .rr      (rr),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  // Address of the granted requester
  always_comb begin
    gnt_addr = addr_in[CHAR];
    case (gnt_id)
      SCR1:    gnt_addr = addr_in[SCR1];
      SCR2:    gnt_addr = addr_in[SCR2];
      default: gnt_addr = addr_in[CHAR];
    endcase
  end

  // Issue reads, track them through the pipeline and capture returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid    <= '0;
      busy     <= '0;
      rr       <= 2'd0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        srv_addr[i] <= '0;
        data_q[i]   <= '0;
      end
      for (int j = 0; j < int'(LAT); j++) flight[j] <= '0;
    end else begin
      mem_rd <= gnt_vld;
      if (gnt_vld) begin
        mem_addr <= gnt_addr;
        rr       <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
      end
      flight[0] <= '{valid: gnt_vld, id: gnt_id, addr: MAP_AW'(gnt_addr)};
      for (int j = 1; j < int'(LAT); j++) flight[j] <= flight[j-1];
      for (int i = 0; i < int'(NREQ); i++) begin
        if (ret_mask[i]) begin
          data_q[i]   <= mem_data;
          srv_addr[i] <= AW'(ret.addr);
          valid[i]    <= 1'b1;
        end
      end
      busy <= (busy & ~ret_mask) | gnt_mask;
    end
  end

endmodule

// File: tb/tb_jts16_map_arb.sv
// Directed bench for the tile-map read arbiter, LAT=2, memory returns addr ^ A5A5.
module tb_jts16_map_arb;

  logic        rst, clk;
  logic [41:0] req_addr;
  logic [47:0] req_data;
  logic [2:0]  req_ok;
  logic [13:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic [13:0] a [3];

  int vectors = 0;
  int miscompares = 0;
  int seen1, seen2, bad;

  assign req_addr = {a[2], a[1], a[0]};

  jts16_map_arb #(.AW(14), .DW(16), .LAT(2)) dut (
    .rst      (rst),
    .clk      (clk),
    .req_addr (req_addr),
    .req_data (req_data),
    .req_ok   (req_ok),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_data (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map RAM with one register stage: data is sampled by the arbiter LAT edges after issue
  always @(posedge clk) mem_data <= 16'(mem_addr) ^ 16'hA5A5;

  function automatic logic [15:0] dat(input int i);
    return req_data[i*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    a[0] = '0; a[1] = '0; a[2] = '0;
    tick(); tick();
    chk("rst_ok", 32'(req_ok), 32'h0);
    chk("rst_data", 32'(req_data[31:0]) | 32'(req_data[47:32]), 32'h0);
    chk("rst_rd", 32'(mem_rd), 32'h0);
    chk("rst_maddr", 32'(mem_addr), 32'h0);
    rst = 1'b0;

    // Initial fill of address 0 for everyone, rr returns to 0
    repeat (8) tick();
    chk("fill_ok", 32'(req_ok), 32'h7);
    chk("fill_d0", 32'(dat(0)), 32'hA5A5);
    chk("fill_d2", 32'(dat(2)), 32'hA5A5);
    chk("fill_rr", 32'(dut.rr), 32'h0);

    // Single request
    a[0] = 14'h0123;
    #1 chk("t1_okdrop", 32'(req_ok[0]), 32'h0);
    tick();
    chk("t1_rd", 32'(mem_rd), 32'h1);
    chk("t1_maddr", 32'(mem_addr), 32'h0123);
    tick();
    chk("t1_rd_idle", 32'(mem_rd), 32'h0);
    chk("t1_ok_e2", 32'(req_ok[0]), 32'h0);
    tick();
    chk("t1_ok_e3", 32'(req_ok[0]), 32'h1);
    chk("t1_data", 32'(dat(0)), 32'hA486);

    // Address change while in flight
    a[1] = 14'h0010;
    tick();
    chk("t3_issue", 32'({mem_rd, mem_addr}), 32'h4010);
    a[1] = 14'h0020;
    tick();
    chk("t3_busy_rd", 32'(mem_rd), 32'h0);
    tick();
    chk("t3_stale_ok", 32'(req_ok[1]), 32'h0);
    chk("t3_stale_data", 32'(dat(1)), 32'hA5B5);
    tick();
    chk("t3_reissue", 32'({mem_rd, mem_addr}), 32'h4020);
    tick();
    chk("t3_ok_e5", 32'(req_ok[1]), 32'h0);
    tick();
    chk("t3_ok_e6", 32'(req_ok[1]), 32'h1);
    chk("t3_data", 32'(dat(1)), 32'hA585);

    // Lone char request brings rr back to 0
    a[2] = 14'h0200;
    tick();
    chk("t2a_issue", 32'({mem_rd, mem_addr}), 32'h4200);
    tick(); tick();
    chk("t2a_data", 32'(dat(2)), 32'hA7A5);
    chk("t2a_rr", 32'(dut.rr), 32'h0);

    // All three change together
    a[0] = 14'h0100; a[1] = 14'h0010; a[2] = 14'h0300;
    tick();
    chk("t2_g0", 32'({mem_rd, mem_addr}), 32'h4100);
    tick();
    chk("t2_g1", 32'({mem_rd, mem_addr}), 32'h4010);
    tick();
    chk("t2_g2", 32'({mem_rd, mem_addr}), 32'h4300);
    chk("t2_ok_e3", 32'(req_ok), 32'h1);
    tick();
    chk("t2_rd_e4", 32'(mem_rd), 32'h0);
    chk("t2_ok_e4", 32'(req_ok), 32'h3);
    tick();
    chk("t2_ok_e5", 32'(req_ok), 32'h7);
    chk("t2_d0", 32'(dat(0)), 32'hA4A5);
    chk("t2_d1", 32'(dat(1)), 32'hA5B5);
    chk("t2_d2", 32'(dat(2)), 32'hA6A5);
    chk("t2_rr", 32'(dut.rr), 32'h0);

    // Requester 0 thrashes; 1 and 2 must still be served promptly
    seen1 = 0; seen2 = 0;
    a[1] = 14'h0040; a[2] = 14'h0050; a[0] = 14'h0200;
    for (int c = 1; c <= 3; c++) begin
      tick();
      a[0] = 14'h0200 + 14'(c);
      if (mem_rd && mem_addr == 14'h0040) seen1 = 1;
      if (mem_rd && mem_addr == 14'h0050) seen2 = 1;
    end
    chk("t4_seen1", 32'(seen1), 32'h1);
    chk("t4_seen2", 32'(seen2), 32'h1);
    for (int c = 4; c <= 6; c++) begin
      tick();
      a[0] = 14'h0200 + 14'(c);
    end
    a[0] = 14'h0210;
    repeat (10) tick();
    chk("t4_ok", 32'(req_ok), 32'h7);
    chk("t4_d0", 32'(dat(0)), 32'hA7B5);
    chk("t4_d1", 32'(dat(1)), 32'hA5E5);
    chk("t4_d2", 32'(dat(2)), 32'hA5F5);

    // Stable addresses generate no traffic
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (mem_rd || req_ok != 3'b111) bad++;
    end
    chk("t5_quiet", 32'(bad), 32'h0);

    // Reset with two reads in flight
    a[0] = 14'h0300; a[1] = 14'h0310;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_ok", 32'(req_ok), 32'h0);
    chk("t6_rst_rd", 32'(mem_rd), 32'h0);
    chk("t6_rst_d0", 32'(dat(0)), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_reissue0", 32'({mem_rd, mem_addr}), 32'h4300);
    chk("t6_late_d1", 32'(dat(1)), 32'h0);
    chk("t6_ok_e4", 32'(req_ok), 32'h0);
    tick();
    chk("t6_reissue1", 32'({mem_rd, mem_addr}), 32'h4310);
    chk("t6_late_d0", 32'(dat(0)), 32'h0);
    tick();
    chk("t6_ok0", 32'(req_ok), 32'h1);
    chk("t6_d0", 32'(dat(0)), 32'hA6A5);
    tick();
    chk("t6_d1", 32'(dat(1)), 32'hA6B5);
    tick();
    chk("t6_ok_all", 32'(req_ok), 32'h7);
    chk("t6_d2", 32'(dat(2)), 32'hA5F5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
